// File: rtl/decoder_3_8.sv
// ============================================================================
// Module   : decoder_3_8
// Brief    : Registered 3-to-8 line decoder with active-high enable, plus a
//            combinational decode tap. Optional macro: DECODER_3_8_INDEX_EN
//            adds a registered index capture (idx) and sticky error flag (err).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder_3_8 #(
    parameter bit OUT_ACTIVE_LOW = 1'b0,
    parameter bit RESET_EN_VAL   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       en,
    output logic [7:0] y,
    output logic [7:0] y_comb,
    output logic       active
`ifdef DECODER_3_8_INDEX_EN
    ,
    output logic [2:0] idx,
    output logic       err
`endif
);

    localparam logic [7:0] c_y_inactive = OUT_ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [2:0] sel_w;
    logic [2:0] sel_n_w;
    logic [7:0] dec_w;
    logic [7:0] y_d;
    logic [7:0] y_q;
    logic       active_d;
    logic       active_q;

    assign sel_w   = {a, b, c};
    assign sel_n_w = ~sel_w;

    // One AND term per output: pick the true or inverted literal of each
    // select bit according to the code this output stands for.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_term
            localparam logic [2:0] c_code = 3'(gi);
            logic lit2_w;
            logic lit1_w;
            logic lit0_w;
            assign lit2_w    = c_code[2] ? sel_w[2] : sel_n_w[2];
            assign lit1_w    = c_code[1] ? sel_w[1] : sel_n_w[1];
            assign lit0_w    = c_code[0] ? sel_w[0] : sel_n_w[0];
            assign dec_w[gi] = en & lit2_w & lit1_w & lit0_w;
        end
    endgenerate

    assign y_comb = OUT_ACTIVE_LOW ? ~dec_w : dec_w;

    always_comb begin
        y_d      = y_comb;
        active_d = en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q      <= c_y_inactive;
            active_q <= RESET_EN_VAL;
        end else begin
            y_q      <= y_d;
            active_q <= active_d;
        end
    end

    assign y      = y_q;
    assign active = active_q;

`ifdef DECODER_3_8_INDEX_EN
    logic [2:0] idx_d;
    logic [2:0] idx_q;
    logic       err_d;
    logic       err_q;
    logic [7:0] y_hi_w;
    logic       multi_hot_w;

    // A vector with more than one bit set still has a bit left after
    // clearing its lowest set bit.
    assign y_hi_w      = OUT_ACTIVE_LOW ? ~y_q : y_q;
    assign multi_hot_w = |(y_hi_w & (y_hi_w - 8'd1));

    always_comb begin
        idx_d = idx_q;
        if (en) begin
            idx_d = sel_w;
        end
        err_d = err_q | multi_hot_w;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= 3'b000;
            err_q <= 1'b0;
        end else begin
            idx_q <= idx_d;
            err_q <= err_d;
        end
    end

    assign idx = idx_q;
    assign err = err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_decoder_3_8.sv
// ============================================================================
// Module   : tb_decoder_3_8
// Brief    : Self-checking bench for decoder_3_8: a vector table plus a
//            randomized run against a reference model; two DUTs cover both
//            output polarities. Honours DECODER_3_8_INDEX_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decoder_3_8;

    logic       clk = 1'b0;
    logic       rst;
    logic       a;
    logic       b;
    logic       c;
    logic       en;
    logic [7:0] y0;
    logic [7:0] yc0;
    logic       act0;
    logic [7:0] y1;
    logic [7:0] yc1;
    logic       act1;
`ifdef DECODER_3_8_INDEX_EN
    logic [2:0] idx0;
    logic       err0;
    logic [2:0] idx1;
    logic       err1;
    logic [2:0] m_idx = 3'b000;
`endif

    int total = 0;
    int bad   = 0;

    always #50 clk = ~clk;

    decoder_3_8 #(.OUT_ACTIVE_LOW(1'b0), .RESET_EN_VAL(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .en(en),
        .y(y0), .y_comb(yc0), .active(act0)
`ifdef DECODER_3_8_INDEX_EN
        , .idx(idx0), .err(err0)
`endif
    );

    decoder_3_8 #(.OUT_ACTIVE_LOW(1'b1), .RESET_EN_VAL(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .en(en),
        .y(y1), .y_comb(yc1), .active(act1)
`ifdef DECODER_3_8_INDEX_EN
        , .idx(idx1), .err(err1)
`endif
    );

    typedef struct {
        logic       r;
        logic       e;
        logic [2:0] code;
        logic [7:0] ey;
        logic       ea;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic e, input logic [2:0] code,
                                input logic [7:0] ey, input logic ea);
        vec_t v;
        v.r = r; v.e = e; v.code = code; v.ey = ey; v.ea = ea;
        return v;
    endfunction

    // Reference decode: the bit whose index equals the code, when enabled.
    function automatic logic [7:0] ref_dec(input logic e, input logic [2:0] code);
        logic [7:0] one;
        one = 8'd1;
        return e ? (one << code) : 8'h00;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Apply one cycle of inputs; check the combinational tap before the edge
    // and both registered DUTs just after it. ey/ea are for the active-high DUT.
    task automatic step(input logic r, input logic e, input logic [2:0] code,
                        input logic [7:0] ey, input logic ea, input string tag);
        rst = r; en = e; {a, b, c} = code;
        #1;
        chk({tag, ".y_comb0"}, yc0, ref_dec(e, code));
        chk({tag, ".y_comb1"}, yc1, ~ref_dec(e, code));
        @(posedge clk);
        #1;
        chk({tag, ".y0"}, y0, ey);
        chk({tag, ".active0"}, {7'd0, act0}, {7'd0, ea});
        chk({tag, ".y1"}, y1, ~ey);
        chk({tag, ".active1"}, {7'd0, act1}, {7'd0, (r ? 1'b1 : e)});
`ifdef DECODER_3_8_INDEX_EN
        if (r) m_idx = 3'b000;
        else if (e) m_idx = code;
        chk({tag, ".idx0"}, {5'd0, idx0}, {5'd0, m_idx});
        chk({tag, ".idx1"}, {5'd0, idx1}, {5'd0, m_idx});
        chk({tag, ".err0"}, {7'd0, err0}, 8'd0);
        chk({tag, ".err1"}, {7'd0, err1}, 8'd0);
`endif
    endtask

    initial begin
        logic       r;
        logic       e;
        logic [2:0] code;
        logic [7:0] ey;

        rst = 1'b1; en = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0;

        // Reset held two edges with en=1, code 5; release loads 8'h20.
        vecs.push_back(mk(1'b1, 1'b1, 3'd5, 8'h00, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 3'd5, 8'h00, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 3'd5, 8'h20, 1'b1));
        // Disabled: every code decodes to nothing.
        for (int i = 0; i < 8; i++) vecs.push_back(mk(1'b0, 1'b0, 3'(i), 8'h00, 1'b0));
        // Enabled sweep, written out as literal expectations.
        vecs.push_back(mk(1'b0, 1'b1, 3'd0, 8'h01, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 3'd1, 8'h02, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 3'd2, 8'h04, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 3'd3, 8'h08, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 3'd4, 8'h10, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 3'd5, 8'h20, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 3'd6, 8'h40, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 3'd7, 8'h80, 1'b1));
        // Reset mid-sweep on code 6, then resume.
        vecs.push_back(mk(1'b0, 1'b1, 3'd4, 8'h10, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 3'd5, 8'h20, 1'b1));
        vecs.push_back(mk(1'b1, 1'b1, 3'd6, 8'h00, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 3'd6, 8'h40, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 3'd7, 8'h80, 1'b1));
        // Inverted-polarity corner: code 2 gives 8'hFB on the active-low DUT.
        vecs.push_back(mk(1'b0, 1'b1, 3'd2, 8'h04, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 3'd2, 8'h00, 1'b0));

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].e, vecs[i].code, vecs[i].ey, vecs[i].ea, $sformatf("vec%0d", i));
        end

        // Hand sequence: idx capture 3, 6, then hold on en=0 with code 1.
        step(1'b0, 1'b1, 3'd3, 8'h08, 1'b1, "seq_idx3");
        step(1'b0, 1'b1, 3'd6, 8'h40, 1'b1, "seq_idx6");
        step(1'b0, 1'b0, 3'd1, 8'h00, 1'b0, "seq_hold");
        // Back-to-back changes after a one-cycle reset pulse.
        step(1'b1, 1'b0, 3'd7, 8'h00, 1'b0, "seq_rst");
        step(1'b0, 1'b1, 3'd7, 8'h80, 1'b1, "seq_b2b7");
        step(1'b0, 1'b1, 3'd0, 8'h01, 1'b1, "seq_b2b0");

        // Randomized run against the reference model.
        for (int n = 0; n < 300; n++) begin
            r    = ($urandom_range(0, 15) == 0);
            e    = ($urandom_range(0, 3) != 0);
            code = 3'($urandom);
            ey   = r ? 8'h00 : ref_dec(e, code);
            step(r, e, code, ey, r ? 1'b0 : e, $sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/decoder_3_8.md
Name: decoder_3_8

Overview:
- Registered 3-to-8 line decoder with active-high enable.
- Converts the 3-bit select code {a,b,c} (a = MSB, c = LSB) into a one-hot 8-bit output y.
- Used as a generic select/strobe generator inside synchronous datapaths. The output is registered on clk, with one cycle of latency.

Parameters:
- OUT_ACTIVE_LOW, default 0: when 1, the driven y (and y_comb) is the bitwise inverse of the active-high decode. Reset value follows the same inversion.
- RESET_EN_VAL, default 0: value loaded into the enable-tracking flag `active` on reset (0 or 1). It affects only `active`, never y.

Ports:
- clk, input, 1: rising-edge clock; the only clock.
- rst, input, 1: synchronous reset, active-high; sampled on the rising edge of clk.
- a, input, 1: select bit 2 (MSB).
- b, input, 1: select bit 1.
- c, input, 1: select bit 0 (LSB).
- en, input, 1: decode enable, active-high.
- y, output, 8: registered decoded output; y[i] corresponds to code i.
- y_comb, output, 8: combinational decode of the current inputs (same polarity rules as y). Provided for zero-latency users.
- active, output, 1: registered copy of en.

Behaviour:
- Active-high decode: d[i] = en & ({a,b,c} == i), for i = 0..7.
- With en=1, exactly one bit of d is 1. With en=0, d = 8'h00.
- y_comb = OUT_ACTIVE_LOW ? ~d : d. It is purely combinational and is not affected by rst.
- Each rising clk edge:
  - if rst=1: y <= (OUT_ACTIVE_LOW ? 8'hFF : 8'h00) and active <= RESET_EN_VAL;
  - else: y <= y_comb and active <= en.
- Latency: inputs sampled at edge N appear on y and active after edge N. There is no combinational path from inputs to y.
- Reset dominates en and the select inputs on the same edge.
- Reset mid-operation: on the next edge y returns to its inactive value, regardless of inputs.
- After reset release, the first non-reset edge loads the decode of the inputs sampled at that edge.
- Inputs at X/Z are not handled specially; behaviour in that case is undefined.
- Encoding examples: code 3'b000 gives y=8'h01, 3'b011 gives y=8'h08, 3'b111 gives y=8'h80 (OUT_ACTIVE_LOW=0).
- Structural core: the 8 decode terms are built from per-bit inverters plus 3-input AND terms gated by en, one instance per output bit. The register stage wraps this core.
- Back-to-back code changes every cycle are supported with no bubbles.

Optional Feature:
- Macro: DECODER_3_8_INDEX_EN.
- When defined, the block adds two ports:
  - idx, output, 3: registered {a,b,c} captured when en=1. idx holds its previous value when en=0 and resets to 3'b000.
  - err, output, 1: registered, sticky. It sets if the registered active-high decode is ever neither one-hot nor all-zero, and clears only on rst.
- When the macro is undefined, these ports and their logic are absent, and the remaining behaviour is identical.

Test Plan:
- rst=1 for 2 edges with en=1, {a,b,c}=3'b101 -> y=8'h00, active=0 during reset. After release, the next edge gives y=8'h20 and active=1.
- en=0 with all 8 codes applied, one per cycle -> y=8'h00 and y_comb=8'h00 throughout; active=0.
- en=1 sweeping codes 000..111, one per 100-time-unit step -> y = 01, 02, 04, 08, 10, 20, 40, 80, each one cycle after the code is applied. y_comb matches immediately.
- rst asserted mid-sweep with code 3'b110 -> y=8'h00 on that edge (not 8'h40); the sweep resumes correctly on the next non-reset edge.
- OUT_ACTIVE_LOW=1 with en=1 and code 3'b010 -> y=8'hFB. Reset gives y=8'hFF; en=0 gives y=8'hFF.
- With DECODER_3_8_INDEX_EN defined: codes 3, 6, then en=0 with code 1 -> idx = 3, 6, 6; err stays 0.
